// File: rtl/scb_pkg.sv
// Shared scoreboard definitions: pipe tags, register-index width and candidate field layout.
// Used by the cell array and by the writeback collector.
package scb_pkg;
  localparam int N_CELL  = 8;
  localparam int W_pip   = 2;
  localparam int W_PA_rx = 5;
  localparam int W_CAND  = 1 + W_pip + W_PA_rx;
  localparam int W_CNT   = 2;
  localparam int N_REG   = 1 << W_PA_rx;

  localparam logic [W_pip-1:0] V_pip0 = 2'b01;
  localparam logic [W_pip-1:0] V_pip1 = 2'b10;

  // Candidate layout, MSB first: {rdy, pip, rd}
  localparam int OFS_RD  = 0;
  localparam int OFS_PIP = W_PA_rx;
  localparam int OFS_RDY = W_PA_rx + W_pip;

  localparam logic [W_CNT-1:0] CNT_MAX = '1;

  // Insert is already blocked at CNT_MAX, so cnt+inc never exceeds CNT_MAX; only the low side clamps.
  function automatic logic [W_CNT-1:0] cnt_next(input logic [W_CNT-1:0] cnt,
                                                input logic inc, input logic [1:0] dec);
    logic [W_CNT+1:0] s;
    logic [W_CNT+1:0] d;
    s = (W_CNT+2)'(cnt) + (W_CNT+2)'(inc);
    d = (W_CNT+2)'(dec);
    if (s < d) return '0;
    return W_CNT'(s - d);
  endfunction
endpackage

// File: rtl/scb_pick_lowest.sv
// Lowest-index priority pick: one-hot grant, any-request flag and a flag for more than one request.
module scb_pick_lowest #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_found,
  output logic         o_multi
);
  assign o_gnt   = i_req & (~i_req + N'(1));
  assign o_found = |i_req;
  assign o_multi = |(i_req & ~o_gnt);
endmodule

// File: rtl/scb_wb_collect_pip1.sv
// Writeback collector for the pipe-1 scoreboard: one pick per pipe per cycle, registered onto the
// writeback ports, plus per-register pending counters exposed as a busy mask.
module scb_wb_collect_pip1
  import scb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CELL*W_CAND-1:0] candit_wb_all,
  input  logic                     ins_valid,
  input  logic [W_PA_rx-1:0]       ins_rd,
  input  logic                     CFI_PC_clear,
  output logic                     wb0_valid,
  output logic [W_PA_rx-1:0]       wb0_rd,
  output logic                     wb1_valid,
  output logic [W_PA_rx-1:0]       wb1_rd,
  output logic [N_REG-1:0]         busy_mask,
  output logic                     cnt_full,
  output logic                     err_conflict,
  output logic                     err_overflow
);
  logic [N_CELL-1:0]             w_req0, w_req1, w_gnt0, w_gnt1;
  logic                          w_fnd0, w_fnd1, w_mul0, w_mul1;
  logic [W_PA_rx-1:0]            w_rd0, w_rd1;
  logic [N_REG-1:0][W_CNT-1:0]   r_cnt, w_cnt_nxt;
  logic                          r_wb0_valid, r_wb1_valid, r_err_conflict, r_err_overflow;
  logic [W_PA_rx-1:0]            r_wb0_rd, r_wb1_rd;

  always_comb begin
    w_req0 = '0;
    w_req1 = '0;
    for (int k = 0; k < N_CELL; k++) begin
      w_req0[k] = candit_wb_all[k*W_CAND+OFS_RDY] &&
                  (candit_wb_all[k*W_CAND+OFS_PIP +: W_pip] == V_pip0);
      w_req1[k] = candit_wb_all[k*W_CAND+OFS_RDY] &&
                  (candit_wb_all[k*W_CAND+OFS_PIP +: W_pip] == V_pip1);
    end
  end

  scb_pick_lowest #(.N(N_CELL)) u_pick0 (
    .i_req(w_req0), .o_gnt(w_gnt0), .o_found(w_fnd0), .o_multi(w_mul0));
  scb_pick_lowest #(.N(N_CELL)) u_pick1 (
    .i_req(w_req1), .o_gnt(w_gnt1), .o_found(w_fnd1), .o_multi(w_mul1));

  // Grants are one-hot, so an AND-OR mux is enough to extract the winning rd.
  always_comb begin
    w_rd0 = '0;
    w_rd1 = '0;
    for (int k = 0; k < N_CELL; k++) begin
      w_rd0 = w_rd0 | ({W_PA_rx{w_gnt0[k]}} & candit_wb_all[k*W_CAND+OFS_RD +: W_PA_rx]);
      w_rd1 = w_rd1 | ({W_PA_rx{w_gnt1[k]}} & candit_wb_all[k*W_CAND+OFS_RD +: W_PA_rx]);
    end
  end

  assign cnt_full = (r_cnt[ins_rd] == CNT_MAX);

  always_comb begin
    logic       inc;
    logic [1:0] dec;
    w_cnt_nxt = '0;
    for (int r = 1; r < N_REG; r++) begin
      inc = ins_valid && (ins_rd == W_PA_rx'(r)) && !cnt_full;
      dec = {1'b0, w_fnd0 && (w_rd0 == W_PA_rx'(r))} + {1'b0, w_fnd1 && (w_rd1 == W_PA_rx'(r))};
      w_cnt_nxt[r] = cnt_next(r_cnt[r], inc, dec);
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < N_REG; r++) busy_mask[r] = |r_cnt[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_wb0_valid    <= 1'b0;
      r_wb1_valid    <= 1'b0;
      r_wb0_rd       <= '0;
      r_wb1_rd       <= '0;
      r_err_conflict <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_conflict <= r_err_conflict | w_mul0 | w_mul1;
      r_err_overflow <= r_err_overflow | (ins_valid & cnt_full);
      if (CFI_PC_clear) begin
        r_cnt       <= '0;
        r_wb0_valid <= 1'b0;
        r_wb1_valid <= 1'b0;
      end else begin
        r_cnt       <= w_cnt_nxt;
        r_wb0_valid <= w_fnd0;
        r_wb1_valid <= w_fnd1;
        if (w_fnd0) r_wb0_rd <= w_rd0;
        if (w_fnd1) r_wb1_rd <= w_rd1;
      end
    end
  end

  assign wb0_valid    = r_wb0_valid;
  assign wb0_rd       = r_wb0_rd;
  assign wb1_valid    = r_wb1_valid;
  assign wb1_rd       = r_wb1_rd;
  assign err_conflict = r_err_conflict;
  assign err_overflow = r_err_overflow;
endmodule

// File: tb/tb_scb_wb_collect_pip1.sv
// Directed bench for scb_wb_collect_pip1: expected writebacks are queued at issue time and a
// negedge monitor pops/compares them; status outputs are checked inline against hand values.
module tb_scb_wb_collect_pip1;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cands;
  logic        ins_valid;
  logic [4:0]  ins_rd;
  logic        clr;
  logic        wb0_valid, wb1_valid, cnt_full, err_conflict, err_overflow;
  logic [4:0]  wb0_rd, wb1_rd;
  logic [31:0] busy_mask;

  int n_chk  = 0;
  int n_fail = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];

  always #5 clk = ~clk;

  scb_wb_collect_pip1 dut (
    .clk(clk), .rst(rst), .candit_wb_all(cands), .ins_valid(ins_valid), .ins_rd(ins_rd),
    .CFI_PC_clear(clr), .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid),
    .wb1_rd(wb1_rd), .busy_mask(busy_mask), .cnt_full(cnt_full),
    .err_conflict(err_conflict), .err_overflow(err_overflow));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cand(input logic [1:0] pip, input logic [4:0] rd);
    return {1'b1, pip, rd};
  endfunction

  task automatic set_cell(input int k, input logic [7:0] v);
    cands[k*8 +: 8] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [4:0] rd);
    ins_valid = 1'b1;
    ins_rd    = rd;
    tick();
    ins_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation for that pipe.
  always @(negedge clk) begin
    if (!rst) begin
      if (wb0_valid) begin
        if (q0.size() == 0) chk("wb0 unexpected valid", 32'(wb0_valid), 32'd0);
        else chk("wb0_rd", 32'(wb0_rd), 32'(q0.pop_front()));
      end
      if (wb1_valid) begin
        if (q1.size() == 0) chk("wb1 unexpected valid", 32'(wb1_valid), 32'd0);
        else chk("wb1_rd", 32'(wb1_rd), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; cands = '0; ins_valid = 1'b0; ins_rd = '0; clr = 1'b0;
    tick(); tick();
    chk("rst wb0_valid", 32'(wb0_valid), 0);
    chk("rst wb1_valid", 32'(wb1_valid), 0);
    chk("rst wb0_rd", 32'(wb0_rd), 0);
    chk("rst wb1_rd", 32'(wb1_rd), 0);
    chk("rst busy_mask", busy_mask, 0);
    chk("rst err_conflict", 32'(err_conflict), 0);
    chk("rst err_overflow", 32'(err_overflow), 0);
    chk("rst cnt_full", 32'(cnt_full), 0);
    rst = 1'b0;

    // single pick on pipe 0
    insert(5'd5);
    chk("busy after insert 5", busy_mask, 32'h20);
    set_cell(3, cand(2'b01, 5'd5)); q0.push_back(5'd5);
    chk("busy before wb 5", busy_mask, 32'h20);
    tick(); cands = '0;
    chk("wb0_valid single", 32'(wb0_valid), 1);
    chk("busy after wb 5", busy_mask, 0);
    tick();
    chk("wb0_valid drops", 32'(wb0_valid), 0);
    chk("wb0_rd holds", 32'(wb0_rd), 5);

    // both pipes in one cycle; decrement of an idle register clamps at 0
    set_cell(1, cand(2'b01, 5'd7)); set_cell(6, cand(2'b10, 5'd9));
    q0.push_back(5'd7); q1.push_back(5'd9);
    tick(); cands = '0;
    chk("dual wb1_valid", 32'(wb1_valid), 1);
    chk("dual err_conflict", 32'(err_conflict), 0);
    chk("dual busy clamp", busy_mask, 0);

    // conflict on pipe 1; a ready cell with pip=11 must be ignored
    set_cell(2, cand(2'b10, 5'd3)); set_cell(4, cand(2'b10, 5'd3)); set_cell(0, cand(2'b11, 5'd6));
    q1.push_back(5'd3);
    tick(); cands = '0;
    chk("conflict err", 32'(err_conflict), 1);
    chk("pip 11 ignored", 32'(wb0_valid), 0);
    tick();
    chk("conflict sticky", 32'(err_conflict), 1);

    // saturation at 3 and overflow
    insert(5'd4); insert(5'd4);
    ins_rd = 5'd4;
    chk("cnt_full at 2", 32'(cnt_full), 0);
    insert(5'd4);
    ins_rd = 5'd4;
    chk("cnt_full at 3", 32'(cnt_full), 1);
    chk("busy rd4", busy_mask, 32'h10);
    insert(5'd4);
    ins_rd = 5'd4;
    chk("err_overflow", 32'(err_overflow), 1);
    chk("count stays 3", 32'(cnt_full), 1);
    for (int i = 0; i < 3; i++) begin
      set_cell(0, cand(2'b01, 5'd4)); q0.push_back(5'd4);
      tick(); cands = '0;
      chk("busy rd4 drain", busy_mask, (i < 2) ? 32'h10 : 32'h0);
    end

    // same-edge insert and writeback net out; double writeback clamps at 0
    insert(5'd10);
    ins_valid = 1'b1; ins_rd = 5'd10;
    set_cell(0, cand(2'b01, 5'd10)); q0.push_back(5'd10);
    tick(); cands = '0; ins_valid = 1'b0;
    chk("net insert+wb", busy_mask, 32'h400);
    set_cell(0, cand(2'b01, 5'd10)); set_cell(1, cand(2'b10, 5'd10));
    q0.push_back(5'd10); q1.push_back(5'd10);
    tick(); cands = '0;
    chk("two wb clamp", busy_mask, 0);

    // flush with a pending pick and insert
    insert(5'd4); insert(5'd8);
    chk("busy before flush", busy_mask, 32'h110);
    clr = 1'b1; ins_valid = 1'b1; ins_rd = 5'd12;
    set_cell(5, cand(2'b01, 5'd4)); set_cell(7, cand(2'b10, 5'd8));
    tick(); cands = '0; clr = 1'b0; ins_valid = 1'b0;
    chk("flush busy", busy_mask, 0);
    chk("flush wb0_valid", 32'(wb0_valid), 0);
    chk("flush wb1_valid", 32'(wb1_valid), 0);
    chk("flush keeps err_conflict", 32'(err_conflict), 1);
    chk("flush keeps err_overflow", 32'(err_overflow), 1);

    // x0 is never counted
    insert(5'd0);
    ins_rd = 5'd0;
    chk("x0 busy", busy_mask, 0);
    chk("x0 cnt_full", 32'(cnt_full), 0);

    tick(); tick();
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
